s2p_frame_ctrl: RTL and testbench

//  Frame controller/sequencer for the serial-to-parallel shift datapath.
//  - Detects start bit on a strobed serial line; gates BITS shift enables into the datapath; checks stop bit.
//  - Captures the assembled word into a holding register with valid/ready handshake to the consumer.
//  - Reports framing and overrun errors as sticky flags.
//  - Sits between the chip serial pins and the parallel consumer logic.

---
 rtl/s2p_frame_ctrl_if.sv | 44 ++++
 rtl/s2p_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_s2p_frame_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_frame_ctrl_if.sv
// Bundle of signals between the frame controller, the serial-to-parallel
// shift datapath and the parallel consumer.
//   bit_stb, serial_in : strobed serial line sample
//   s2p_clr, s2p_shift : datapath controls (combinational)
//   s2p_data           : datapath parallel word (registered in the datapath)
//   word_out/valid/ready : holding register and consumer handshake
//   frame_err, overrun_err, err_clr : sticky error flags and their clear
//   busy               : controller is inside a frame
//   state_dbg          : current FSM state encoding, for observation
// Handshake: word_out is offered while word_valid=1 and is taken by the
// consumer on any rising clk edge where word_valid & word_ready are both 1.
// word_valid never drops without such a transfer, and word_out is stable
// while word_valid=1 unless a transfer and a new load share the same edge.
interface s2p_frame_ctrl_if #(
  parameter int BITS = 4
);
  logic            bit_stb;
  logic            serial_in;
  logic            s2p_clr;
  logic            s2p_shift;
  logic [BITS-1:0] s2p_data;
  logic [BITS-1:0] word_out;
  logic            word_valid;
  logic            word_ready;
  logic            frame_err;
  logic            overrun_err;
  logic            err_clr;
  logic            busy;
  logic [1:0]      state_dbg;

  // Controller side
  modport master (
    input  bit_stb, serial_in, s2p_data, word_ready, err_clr,
    output s2p_clr, s2p_shift, word_out, word_valid, frame_err, overrun_err,
           busy, state_dbg
  );

  // Environment side (pins, datapath, consumer)
  modport slave (
    output bit_stb, serial_in, s2p_data, word_ready, err_clr,
    input  s2p_clr, s2p_shift, word_out, word_valid, frame_err, overrun_err,
           busy, state_dbg
  );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Frame controller for the serial-to-parallel shift datapath.
// Waits for a start bit (line high) on a strobed serial line, gates exactly
// BITS shift enables into the external datapath, then checks the stop bit
// (must be low). A good frame is copied into a holding register offered to
// the consumer with a valid/ready handshake. A bad stop bit sets the sticky
// frame_err; a good frame arriving while the holding register is still full
// and not being taken sets the sticky overrun_err and is dropped.
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : synchronous, active-high; aborts any frame in progress
//   bus   : s2p_frame_ctrl_if master modport (see interface header)
module s2p_frame_ctrl #(
  parameter  int BITS  = 4,
  localparam int CNT_W = $clog2(BITS) + 1
) (
  input logic               clk,
  input logic               reset,
  s2p_frame_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [BITS-1:0]  word_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_err_q;

  logic             clr_c;
  logic             shift_c;
  logic             load_c;
  logic             frm_set_c;
  logic             ovr_set_c;
  logic             accept_c;

  assign accept_c = valid_q & bus.word_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    clr_c     = 1'b0;
    shift_c   = 1'b0;
    load_c    = 1'b0;
    frm_set_c = 1'b0;
    ovr_set_c = 1'b0;
    case (state)
      IDLE: begin
        // A low line while idle is just the idle level, not a start bit.
        if (bus.bit_stb && bus.serial_in) begin
          clr_c     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_stb) begin
          shift_c = 1'b1;
          cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // The datapath already holds the full word here.
        if (bus.bit_stb) begin
          state_nxt = IDLE;
          if (bus.serial_in) begin
            frm_set_c = 1'b1;
          end else if (!valid_q || bus.word_ready) begin
            // Holding register is empty, or is being emptied on this edge.
            load_c = 1'b1;
          end else begin
            ovr_set_c = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_c) begin
      word_q  <= bus.s2p_data;
      valid_q <= 1'b1;
    end else if (accept_c) begin
      valid_q <= 1'b0;
    end
  end

  // A new error wins over a same-cycle clear, independently per flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (frm_set_c) begin
        frame_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        frame_err_q <= 1'b0;
      end
      if (ovr_set_c) begin
        overrun_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        overrun_err_q <= 1'b0;
      end
    end
  end

  assign bus.s2p_clr     = clr_c;
  assign bus.s2p_shift   = shift_c;
  assign bus.word_out    = word_q;
  assign bus.word_valid  = valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign bus.busy        = (state != IDLE);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl with BITS=4. Includes a behavioural shift
// datapath (clear, or shift left taking serial_in into bit 0), so the first
// data bit on the line ends up as the word MSB.
// Inputs change 1 time unit after a rising edge; outputs are read on the
// falling edge or 1 unit after a rising edge.
module tb_s2p_frame_ctrl;
  localparam int BITS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  s2p_frame_ctrl_if #(.BITS(BITS)) bus ();

  s2p_frame_ctrl #(.BITS(BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Datapath model
  logic [BITS-1:0] dp;
  always_ff @(posedge clk) begin
    if (reset)              dp <= '0;
    else if (bus.s2p_clr)   dp <= '0;
    else if (bus.s2p_shift) dp <= {dp[BITS-2:0], bus.serial_in};
  end
  assign bus.s2p_data = dp;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] exp_q[$];
  int shift_cnt = 0;
  int clr_cnt = 0;
  logic ready_idle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse counters and clr/shift exclusivity
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.s2p_shift) shift_cnt++;
      if (bus.s2p_clr)   clr_cnt++;
      if (bus.s2p_shift || bus.s2p_clr) begin
        checks++;
        if (bus.s2p_shift && bus.s2p_clr) begin
          errors++;
          $display("FAIL clr_shift_overlap: got both 1 expected exclusive");
        end
      end
    end
  end

  // Scoreboard monitor: every transfer must match the oldest expected word
  always @(negedge clk) begin
    if (!reset && bus.word_valid && bus.word_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_xfer: got %0h expected no word", bus.word_out);
      end else begin
        logic [BITS-1:0] e;
        e = exp_q.pop_front();
        if (bus.word_out !== e) begin
          errors++;
          $display("FAIL word_xfer: got %0h expected %0h", bus.word_out, e);
        end
      end
    end
  end

  // Entry/exit at posedge+1. ctl[0]: err_clr, ctl[1]: word_ready during the pulse.
  task automatic strobe(input logic v, input int gap, input logic [1:0] ctl);
    repeat (gap - 1) @(posedge clk);
    #1;
    bus.bit_stb    = 1'b1;
    bus.serial_in  = v;
    bus.err_clr    = ctl[0];
    bus.word_ready = ready_idle | ctl[1];
    @(posedge clk);
    #1;
    bus.bit_stb    = 1'b0;
    bus.serial_in  = 1'b0;
    bus.err_clr    = 1'b0;
    bus.word_ready = ready_idle;
  endtask

  task automatic frame(input logic [BITS-1:0] data, input logic stop, input int gap,
                       input logic [1:0] stop_ctl);
    strobe(1'b1, gap, 2'b00);
    for (int i = BITS - 1; i >= 0; i--) strobe(data[i], gap, 2'b00);
    strobe(stop, gap, stop_ctl);
  endtask

  task automatic pulse_ready();
    bus.word_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.word_ready = ready_idle;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0;
    reset          = 1'b1;
    bus.bit_stb    = 1'b0;
    bus.serial_in  = 1'b0;
    bus.word_ready = 1'b0;
    bus.err_clr    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.word_valid, 0);
    check("rst_word", bus.word_out, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun_err, 0);
    check("rst_state", bus.state_dbg, 0);

    // T1: serial 1,1,0,1,1,0 -> word 1011
    s0 = shift_cnt;
    exp_q.push_back(4'b1011);
    frame(4'b1011, 1'b0, 3, 2'b00);
    check("t1_shifts", shift_cnt - s0, 4);
    check("t1_valid", bus.word_valid, 1);
    check("t1_word", bus.word_out, 4'b1011);
    check("t1_busy", bus.busy, 0);
    pulse_ready();
    check("t1_valid_drop", bus.word_valid, 0);

    // T2: bad stop bit, clear, then clear coincident with a new error
    frame(4'b0101, 1'b1, 3, 2'b00);
    check("t2_frame_err", bus.frame_err, 1);
    check("t2_valid", bus.word_valid, 0);
    pulse_clr();
    check("t2_cleared", bus.frame_err, 0);
    frame(4'b0110, 1'b1, 3, 2'b01);
    check("t2_set_wins", bus.frame_err, 1);
    check("t2_no_overrun", bus.overrun_err, 0);
    pulse_clr();
    check("t2_cleared2", bus.frame_err, 0);

    // T3a: two good frames, consumer not ready -> overrun, first word kept
    exp_q.push_back(4'b0110);
    frame(4'b0110, 1'b0, 3, 2'b00);
    frame(4'b1001, 1'b0, 3, 2'b00);
    check("t3_overrun", bus.overrun_err, 1);
    check("t3_valid", bus.word_valid, 1);
    check("t3_word_kept", bus.word_out, 4'b0110);
    pulse_ready();
    check("t3_valid_drop", bus.word_valid, 0);
    pulse_clr();
    check("t3_ovr_cleared", bus.overrun_err, 0);

    // T3b: ready at the second stop edge -> swap in the new word
    exp_q.push_back(4'b0011);
    frame(4'b0011, 1'b0, 3, 2'b00);
    exp_q.push_back(4'b1100);
    frame(4'b1100, 1'b0, 3, 2'b10);
    check("t3b_valid", bus.word_valid, 1);
    check("t3b_word", bus.word_out, 4'b1100);
    check("t3b_no_overrun", bus.overrun_err, 0);
    pulse_ready();

    // T4: reset after two data strobes aborts the frame
    strobe(1'b1, 3, 2'b00);
    strobe(1'b1, 3, 2'b00);
    strobe(1'b0, 3, 2'b00);
    check("t4_busy_mid", bus.busy, 1);
    do_reset();
    check("t4_busy", bus.busy, 0);
    check("t4_valid", bus.word_valid, 0);
    check("t4_frame_err", bus.frame_err, 0);
    check("t4_overrun", bus.overrun_err, 0);
    exp_q.push_back(4'b1101);
    frame(4'b1101, 1'b0, 3, 2'b00);
    check("t4_word", bus.word_out, 4'b1101);
    pulse_ready();

    // T5: idle-low line, then back-to-back frames with strobe every clock
    ready_idle     = 1'b1;
    bus.word_ready = 1'b1;
    c0 = clr_cnt;
    s0 = shift_cnt;
    for (int i = 0; i < 3; i++) strobe(1'b0, 1, 2'b00);
    check("t5_idle_no_clr", clr_cnt - c0, 0);
    check("t5_idle_busy", bus.busy, 0);
    exp_q.push_back(4'b1010);
    frame(4'b1010, 1'b0, 1, 2'b00);
    exp_q.push_back(4'b0101);
    frame(4'b0101, 1'b0, 1, 2'b00);
    exp_q.push_back(4'b1111);
    frame(4'b1111, 1'b0, 1, 2'b00);
    exp_q.push_back(4'b0000);
    frame(4'b0000, 1'b0, 1, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("t5_clr_count", clr_cnt - c0, 4);
    check("t5_shift_count", shift_cnt - s0, 16);
    check("t5_no_errors", {bus.frame_err, bus.overrun_err}, 0);
    check("t5_valid_drained", bus.word_valid, 0);
    check("all_words_seen", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
